// File: rtl/st_rr_stream_arbiter.sv
// Round-robin Avalon-ST stream arbiter.
// Merges NUM_IN source streams into one output stream and tags each beat
// with its source index. A grant lasts until MAX_BURST beats have been sent
// or the granted source drops valid. A single IDLE cycle separates grants,
// and the next grant goes to the first requester after the previous one.
module st_rr_stream_arbiter #(
    parameter int DATA_W    = 256,
    parameter int NUM_IN    = 4,
    parameter int MAX_BURST = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_IN-1:0]        in_valid,
    input  logic [NUM_IN*DATA_W-1:0] in_data,
    output logic [NUM_IN-1:0]        in_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [2:0]               out_channel,
    input  logic                     out_ready,
    output logic [31:0]              beat_count
);

    localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } stateT;

    stateT              state_q;
    logic [IDX_W-1:0]   grant_q;
    logic [IDX_W-1:0]   lastGrant_q;
    logic [7:0]         burstCnt_q;
    logic [31:0]        beatCount_q;

    logic [7:0]         burstCnt_d;
    logic [31:0]        beatCount_d;
    logic [IDX_W-1:0]   pickIdx;
    logic [2*NUM_IN-1:0] reqTwice;
    logic               grantValid;
    logic               xfer;
    logic               burstDone;

    // Doubling the request vector lets the round-robin search run upward
    // from lastGrant+1 without explicit wrap-around in the index.
    assign reqTwice    = {in_valid, in_valid};
    assign grantValid  = in_valid[grant_q];
    assign xfer        = (state_q == GRANT) && grantValid && out_ready;
    assign burstCnt_d  = burstCnt_q + 8'd1;
    assign beatCount_d = beatCount_q + 32'd1;
    assign burstDone   = (burstCnt_q == 8'(MAX_BURST - 1));
    assign beat_count  = beatCount_q;

    // Pick the first requester after the last grant; searching downward means the nearest one wins.
    always_comb begin
        pickIdx = lastGrant_q;
        for (int k = NUM_IN; k >= 1; k--) begin
            if (reqTwice[int'(lastGrant_q) + k]) begin
                pickIdx = IDX_W'((int'(lastGrant_q) + k) % NUM_IN);
            end
        end
    end

    // Zero-latency datapath: route the granted source straight to the output while in GRANT.
    always_comb begin
        out_valid   = 1'b0;
        out_data    = '0;
        out_channel = 3'd0;
        in_ready    = '0;
        if (state_q == GRANT) begin
            out_valid         = grantValid;
            out_data          = in_data[grant_q*DATA_W +: DATA_W];
            out_channel       = 3'(grant_q);
            in_ready[grant_q] = out_ready;
        end
    end

    // Grant FSM with burst and beat counters; backpressure holds the grant, a valid gap releases it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            lastGrant_q <= IDX_W'(NUM_IN - 1);
            burstCnt_q  <= 8'd0;
            beatCount_q <= 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|in_valid) begin
                        grant_q    <= pickIdx;
                        burstCnt_q <= 8'd0;
                        state_q    <= GRANT;
                    end
                end
                GRANT: begin
                    if (!grantValid) begin
                        state_q     <= IDLE;
                        lastGrant_q <= grant_q;
                    end else if (xfer) begin
                        burstCnt_q  <= burstCnt_d;
                        beatCount_q <= beatCount_d;
                        if (burstDone) begin
                            state_q     <= IDLE;
                            lastGrant_q <= grant_q;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_st_rr_stream_arbiter.sv
// Testbench for st_rr_stream_arbiter.
// Each cycle's stimulus pushes the expected output onto a queue, and a
// negedge monitor pops and compares. Sources emit payload {index, beat#}.
module tb_st_rr_stream_arbiter;

    localparam int DW  = 32;
    localparam int NIN = 4;
    localparam int MB  = 8;

    typedef struct {
        logic        v;
        logic [2:0]  ch;
        logic [31:0] d;
        logic [3:0]  rdy;
    } expT;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [NIN-1:0]    inValid = '0;
    logic [NIN*DW-1:0] inData;
    logic [NIN-1:0]    inReady;
    logic              outValid;
    logic [DW-1:0]     outData;
    logic [2:0]        outChannel;
    logic              outReady = 1'b0;
    logic [31:0]       beatCount;

    expT               expQ[$];
    logic [23:0]       sentCnt [NIN];
    int                expK [NIN];
    int                checkCount = 0;
    int                errorCount = 0;

    st_rr_stream_arbiter #(
        .DATA_W   (DW),
        .NUM_IN   (NIN),
        .MAX_BURST(MB)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (inValid),
        .in_data    (inData),
        .in_ready   (inReady),
        .out_valid  (outValid),
        .out_data   (outData),
        .out_channel(outChannel),
        .out_ready  (outReady),
        .beat_count (beatCount)
    );

    always #5 clk = ~clk;

    // Each source presents {index, beats accepted so far}.
    for (genvar i = 0; i < NIN; i++) begin : gSrc
        assign inData[i*DW +: DW] = {8'(i), sentCnt[i]};
    end

    // Source model: advance a source's beat number whenever it is accepted.
    always @(posedge clk or negedge reset_n) begin
        for (int i = 0; i < NIN; i++) begin
            if (!reset_n) sentCnt[i] <= 24'd0;
            else if (inValid[i] && inReady[i]) sentCnt[i] <= sentCnt[i] + 24'd1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checkCount++;
        if (obs !== expv) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, expv, $time);
        end
    endtask

    // Monitor: compare every cycle that has a queued expectation.
    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            expT e;
            e = expQ.pop_front();
            checkOutput("out_valid", 32'(outValid), 32'(e.v));
            checkOutput("out_channel", 32'(outChannel), 32'(e.ch));
            checkOutput("out_data", outData, e.d);
            checkOutput("in_ready", 32'(inReady), 32'(e.rdy));
        end
    end

    task automatic applyStimulus(input logic [3:0] v, input logic r, input logic ev,
                                 input int ech, input logic [31:0] ed, input logic [3:0] erdy);
        expT e;
        @(posedge clk);
        #1;
        inValid  = v;
        outReady = r;
        e.v   = ev;
        e.ch  = 3'(ech);
        e.d   = ed;
        e.rdy = erdy;
        expQ.push_back(e);
    endtask

    task automatic stepIdle(input logic [3:0] v);
        applyStimulus(v, 1'b1, 1'b0, 0, 32'd0, 4'd0);
    endtask

    task automatic stepXfer(input logic [3:0] v, input int ch);
        applyStimulus(v, 1'b1, 1'b1, ch, {8'(ch), 24'(expK[ch])}, 4'(1 << ch));
        expK[ch]++;
    endtask

    task automatic stepStall(input logic [3:0] v, input int ch);
        applyStimulus(v, 1'b0, 1'b1, ch, {8'(ch), 24'(expK[ch])}, 4'd0);
    endtask

    task automatic stepGap(input logic [3:0] v, input int ch);
        applyStimulus(v, 1'b1, 1'b0, ch, {8'(ch), 24'(expK[ch])}, 4'(1 << ch));
    endtask

    task automatic burst(input logic [3:0] v, input int ch);
        for (int b = 0; b < MB; b++) stepXfer(v, ch);
    endtask

    task automatic checkBeats(input string tag, input logic [31:0] expv);
        @(negedge clk);
        checkOutput(tag, beatCount, expv);
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        reset_n  = 1'b0;
        inValid  = 4'b1111;
        outReady = 1'b1;
        for (int i = 0; i < NIN; i++) expK[i] = 0;
        @(negedge clk);
        checkOutput("rst_out_valid", 32'(outValid), 32'd0);
        checkOutput("rst_in_ready", 32'(inReady), 32'd0);
        checkOutput("rst_out_data", outData, 32'd0);
        checkOutput("rst_out_channel", 32'(outChannel), 32'd0);
        checkOutput("rst_beat_count", beatCount, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        inValid = 4'b0000;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < NIN; i++) expK[i] = 0;

        // Single source: two full bursts separated by one idle cycle.
        doReset();
        stepIdle(4'b0001);
        burst(4'b0001, 0);
        stepIdle(4'b0001);
        burst(4'b0001, 0);
        stepIdle(4'b0000);
        checkBeats("single_beats", 32'd16);

        // Fairness: all sources requesting, round-robin 0,1,2,3,0.
        doReset();
        stepIdle(4'b1111);
        burst(4'b1111, 0);
        stepIdle(4'b1111);
        burst(4'b1111, 1);
        stepIdle(4'b1111);
        burst(4'b1111, 2);
        stepIdle(4'b1111);
        burst(4'b1111, 3);
        stepIdle(4'b1111);
        burst(4'b1111, 0);
        stepIdle(4'b0000);
        checkBeats("fair_beats", 32'd40);

        // Backpressure on source 2: alternating ready, burst still 8 transfers.
        doReset();
        stepIdle(4'b0100);
        for (int b = 0; b < MB; b++) begin
            stepXfer(4'b0100, 2);
            if (b < MB - 1) stepStall(4'b0100, 2);
        end
        stepIdle(4'b0000);
        checkBeats("bp_beats", 32'd8);

        // Gap release: source 1 drops after 3 beats, source 3 served next, then 1 again.
        doReset();
        stepIdle(4'b1010);
        for (int b = 0; b < 3; b++) stepXfer(4'b1010, 1);
        stepGap(4'b1000, 1);
        stepIdle(4'b1000);
        for (int b = 0; b < MB; b++) stepXfer(b >= 2 ? 4'b1010 : 4'b1000, 3);
        stepIdle(4'b1010);
        burst(4'b1010, 1);
        stepIdle(4'b0000);
        checkBeats("gap_beats", 32'd19);

        // Reset mid-burst during beat 5 of source 2, then restart from source 0 priority.
        doReset();
        stepIdle(4'b0100);
        for (int b = 0; b < 4; b++) stepXfer(4'b0100, 2);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(negedge clk);
        checkOutput("midrst_out_valid", 32'(outValid), 32'd0);
        checkOutput("midrst_in_ready", 32'(inReady), 32'd0);
        checkOutput("midrst_out_data", outData, 32'd0);
        checkOutput("midrst_out_channel", 32'(outChannel), 32'd0);
        checkOutput("midrst_beat_count", beatCount, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        inValid = 4'b0000;
        for (int i = 0; i < NIN; i++) expK[i] = 0;
        stepIdle(4'b0110);
        checkBeats("postrst_beats", 32'd0);
        burst(4'b0110, 1);
        stepIdle(4'b0000);
        checkBeats("postrst_after", 32'd8);

        // Counter wrap: preload near the top and send 3 beats.
        doReset();
        @(posedge clk);
        #1;
        force dut.beatCount_q = 32'hFFFF_FFFE;
        #1;
        release dut.beatCount_q;
        stepIdle(4'b0001);
        for (int b = 0; b < 3; b++) stepXfer(4'b0001, 0);
        stepGap(4'b0000, 0);
        stepIdle(4'b0000);
        checkBeats("wrap_beats", 32'h0000_0001);

        @(posedge clk);
        @(negedge clk);
        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
